// File: rtl/jpeg_stream_ctrl.sv
// JPEG stream controller: fetches pixel words for the coding pipeline
// and packs the coded bytes it returns into words for the output buffer.
`timescale 1ns/1ps
module jpeg_stream_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [31:0]       byte_count,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic              rd_wait,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic [7:0]        px_out,
  output logic              px_ena,
  input  logic              px_rdy,
  output logic              image_done,
  input  logic [15:0]       bits_in,
  input  logic [1:0]        bits_valid,
  input  logic              bits_ena,
  output logic              bits_rdy,
  input  logic              flush_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_req,
  input  logic              wr_wait
);

  localparam int PW = 2 * DIM_W;
  localparam logic [PW-1:0]     PX4  = PW'(4);
  localparam logic [ADDR_W-1:0] AINC = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, FEED, END_IMG, DRAIN
  } state_t;

  state_t            state;
  logic [PW-1:0]     pix_left;
  logic [31:0]       word_q;
  logic [1:0]        sel;
  logic [1:0]        nsel;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] words_written;
  logic              wr_pending;
  logic              flush_flag;
  logic [23:0]       res_q;
  logic [1:0]        res_cnt;
  logic [31:0]       hold_q;
  logic [31:0]       byte_acc;
  logic              acc;
  logic              fin;
  logic              flush_wr;
  logic              start_go;
  logic [1:0]        n_in;
  logic [2:0]        sum;
  logic [2:0]        sum_m4;
  logic [15:0]       new2;
  logic [39:0]       tmp;

  assign bits_rdy = busy & ~wr_pending;
  assign wr_req   = wr_pending;
  assign wr_data  = hold_q;
  assign wr_addr  = dst_q + {words_written[ADDR_W-3:0], 2'b00};
  assign nsel     = sel + 2'd1;

  // Byte append math for an accepted beat and end-of-image decisions
  always_comb begin
    acc      = bits_ena & bits_rdy & (bits_valid != 2'd0);
    n_in     = bits_valid[1] ? 2'd2 : 2'd1;
    new2     = bits_valid[1] ? {bits_in[7:0], bits_in[15:8]}
                             : {8'h00, bits_in[15:8]};
    tmp      = {16'h0, res_q} | ({24'h0, new2} << {res_cnt, 3'b000});
    sum      = {1'b0, res_cnt} + {1'b0, n_in};
    sum_m4   = sum - 3'd4;
    start_go = (state == IDLE) & start;
    flush_wr = (state == DRAIN) & flush_flag & ~wr_pending
             & (res_cnt != 2'd0) & ~acc;
    fin      = (state == DRAIN) & flush_flag & ~wr_pending
             & (res_cnt == 2'd0) & ~acc;
  end

  // Fetch FSM: read one word, feed its four pixels, repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
      rd_addr    <= '0;
      rd_req     <= 1'b0;
      px_out     <= '0;
      px_ena     <= 1'b0;
      image_done <= 1'b0;
      pix_left   <= '0;
      word_q     <= '0;
      sel        <= '0;
      dst_q      <= '0;
    end else begin
      done       <= 1'b0;
      image_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dst_q <= dst_base;
            if (width == '0 || height == '0) begin
              done       <= 1'b1;
              byte_count <= '0;
            end else begin
              pix_left <= {{DIM_W{1'b0}}, width}
                        * {{DIM_W{1'b0}}, height};
              rd_addr  <= src_base;
              rd_req   <= 1'b1;
              busy     <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!rd_wait) begin
            rd_req  <= 1'b0;
            rd_addr <= rd_addr + AINC;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_valid) begin
            word_q <= rd_data;
            sel    <= 2'd0;
            px_out <= rd_data[7:0];
            px_ena <= 1'b1;
            state  <= FEED;
          end
        end
        FEED: begin
          if (px_rdy) begin
            if (sel == 2'd3) begin
              px_ena   <= 1'b0;
              pix_left <= pix_left - PX4;
              if (pix_left > PX4) begin
                rd_req <= 1'b1;
                state  <= RD_REQ;
              end else begin
                image_done <= 1'b1;
                state      <= END_IMG;
              end
            end else begin
              sel    <= nsel;
              px_out <= word_q[{nsel, 3'b000} +: 8];
            end
          end
        end
        END_IMG: state <= DRAIN;
        DRAIN: begin
          if (fin) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            byte_count <= byte_acc;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output packer: residual bytes, write-holding word, flush handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q         <= '0;
      res_cnt       <= '0;
      hold_q        <= '0;
      wr_pending    <= 1'b0;
      words_written <= '0;
      byte_acc      <= '0;
      flush_flag    <= 1'b0;
    end else if (start_go) begin
      res_q         <= '0;
      res_cnt       <= '0;
      hold_q        <= '0;
      wr_pending    <= 1'b0;
      words_written <= '0;
      byte_acc      <= '0;
      flush_flag    <= 1'b0;
    end else begin
      if (wr_pending && !wr_wait) begin
        wr_pending    <= 1'b0;
        words_written <= words_written + AONE;
      end
      if (acc) begin
        byte_acc <= byte_acc + {30'h0, n_in};
        if (sum[2]) begin
          hold_q     <= tmp[31:0];
          wr_pending <= 1'b1;
          res_q      <= {16'h0, tmp[39:32]};
          res_cnt    <= sum_m4[1:0];
        end else begin
          res_q   <= tmp[23:0];
          res_cnt <= sum[1:0];
        end
      end
      if (flush_wr) begin
        hold_q     <= {8'h00, res_q};
        wr_pending <= 1'b1;
        res_q      <= '0;
        res_cnt    <= '0;
      end
      if (state == DRAIN && flush_done)
        flush_flag <= 1'b1;
    end
  end

endmodule

// File: doc/jpeg_stream_ctrl.md
JPEG_STREAM_CTRL -- requirements
Module: jpeg_stream_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both memory ports.
REQ-002 SHALL have parameter DIM_W, default 12, width of the image dimension inputs.
REQ-003 SHALL have these ports:
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one image, sampled in IDLE
- width  in  DIM_W  pixels per row, multiple of 8
- height  in  DIM_W  rows, multiple of 8
- src_base  in  ADDR_W  pixel buffer base, word aligned
- dst_base  in  ADDR_W  output buffer base, word aligned
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- byte_count  out  32  bytes written for the last image
- rd_addr  out  ADDR_W  read address
- rd_req  out  1  read request
- rd_wait  in  1  read stall
- rd_valid  in  1  read data valid
- rd_data  in  32  4 pixels, byte 0 = first pixel
- px_out  out  8  pixel to the pipeline
- px_ena  out  1  pixel valid
- px_rdy  in  1  pipeline ready for a pixel
- image_done  out  1  end-of-image pulse to the pipeline
- bits_in  in  16  coded bytes from the pipeline
- bits_valid  in  2  valid byte count: 0, 1 ([15:8]) or 2 ([15:8] then [7:0])
- bits_ena  in  1  coded data valid
- bits_rdy  out  1  controller can accept coded data
- flush_done  in  1  pipeline flush complete
- wr_addr  out  ADDR_W  write address
- wr_data  out  32  4 bytes, first byte in [7:0]
- wr_req  out  1  write request
- wr_wait  in  1  write stall

Function
REQ-004 A transfer on any ena/rdy pair SHALL occur on a clk edge where both are high.
REQ-005 A memory request SHALL complete on an edge where req=1 and wait=0; addr, data and req SHALL be held while wait=1.
REQ-006 The fetch FSM SHALL have states IDLE, RD_REQ, RD_WAIT, FEED, END_IMG and DRAIN.
REQ-007 IDLE and start=1 SHALL latch all configuration inputs, clear the counters and enter RD_REQ; rd_req SHALL assert with rd_addr=src_base on the next cycle.
REQ-008 width=0 or height=0 at start SHALL pulse done one cycle later with byte_count=0, issue no memory traffic and return to IDLE.
REQ-009 RD_REQ SHALL go to RD_WAIT when the request completes; RD_WAIT SHALL capture rd_data on rd_valid=1 and enter FEED.
REQ-010 At most one read SHALL be outstanding; rd_addr SHALL advance by 4 per request.
REQ-011 FEED SHALL present bytes 0..3 in order on px_out with px_ena=1, advancing on each px_rdy handshake.
REQ-012 After byte 3, FEED SHALL enter RD_REQ if pixels remain, otherwise END_IMG; total pixels SHALL equal width*height.
REQ-013 END_IMG SHALL drive image_done=1 for exactly one cycle, then enter DRAIN.
REQ-014 The output packer SHALL run in every non-IDLE state, in parallel with fetching.
REQ-015 The packer SHALL hold 0..3 residual bytes plus one write-holding word.
- bits_rdy SHALL equal busy AND NOT wr_pending.
- An accepted bits_valid=0 beat SHALL be discarded.
REQ-016 On accept, bytes SHALL append in the order of REQ-003.
- When the residual count reaches 4 or more, the oldest 4 bytes SHALL load the holding word and set wr_pending; the remaining 0 or 1 byte SHALL stay residual.
REQ-017 While wr_pending=1, wr_req SHALL be high with wr_addr=dst_base+4*words_written; completion SHALL clear wr_pending and increment words_written.
REQ-018 In DRAIN, flush_done=1 SHALL set a flush flag.
- When the flag is set, wr_pending=0 and residual>0, the residual bytes SHALL be written as one word with unused upper bytes zero.
REQ-019 After the final write completes, or immediately if none is needed:
- byte_count SHALL be updated to the exact number of bytes accepted.
- done SHALL pulse for one cycle.
- The FSM SHALL return to IDLE.
REQ-020 byte_count SHALL hold its value until the next start; the counter SHALL be 32 bits and SHALL wrap modulo 2^32.
REQ-021 flush_done or bits_ena received in IDLE SHALL be ignored; start while busy SHALL be ignored.
REQ-022 bits_ena and a completing write on the same edge SHALL be handled without byte loss; bits_rdy is low that cycle per REQ-015.

Reset
REQ-023 While rst=1 the block SHALL be in IDLE with these outputs 0: busy, done, byte_count, rd_req, px_ena, image_done, bits_rdy, wr_req, rd_addr, wr_addr, wr_data and px_out.
REQ-024 Reset asserted mid-image SHALL drop all in-flight requests, residual bytes and the holding word with no further memory traffic; the pipeline is reset separately.

Verification
REQ-025 The bench SHALL cover these scenarios:
- 8x8 image, src_base=0x1000, memory always ready -> 16 reads at 0x1000..0x103C, 64 pixels in order, one image_done after the 64th pixel.
- The pipeline returns 5 bytes as beats of 2, 2 and 1, then flush_done -> writes at dst_base and dst_base+4, the second word 0x000000ee where ee is byte 5, byte_count=5, done pulse.
- rd_wait and wr_wait held randomly 0-3 cycles, px_rdy toggling -> identical pixel order and output words, with addresses stable during stalls.
- width=0 -> done pulse 1 cycle after start, byte_count=0, no rd_req.
- rst asserted while in FEED -> next-cycle outputs all per REQ-023; a following start for a 16x8 image completes normally.
- start pulsed while busy -> ignored, no address restart.
